// File: rtl/ann_pkg.sv
// ann_pkg: shared layer geometry, state encoding and per-layer helpers for the ANN sequencer.
package ann_pkg;
    localparam int INPUT_LAYER  = 16;
    localparam int SECOND_LAYER = 4;
    localparam int THIRD_LAYER  = 1;
    localparam int COEF_ADDR_W  = 8;
    localparam int BASE_L0      = 0;
    localparam int BASE_L1      = INPUT_LAYER * SECOND_LAYER;
    localparam int IN_W   = $clog2(INPUT_LAYER > SECOND_LAYER ? INPUT_LAYER : SECOND_LAYER);
    localparam int NODE_W = $clog2(SECOND_LAYER > THIRD_LAYER ? SECOND_LAYER : THIRD_LAYER);
    typedef enum logic [2:0] {IDLE, WAIT_LOAD, CLEAR, REQ, ACCUM, STORE, DONE} seq_state_t;
    function automatic int fan_in(input logic layer);
        return layer ? SECOND_LAYER : INPUT_LAYER;
    endfunction
    function automatic int nodes(input logic layer);
        return layer ? THIRD_LAYER : SECOND_LAYER;
    endfunction
    function automatic int base(input logic layer);
        return layer ? BASE_L1 : BASE_L0;
    endfunction
endpackage

// File: rtl/ann_coef_addr_gen.sv
// ann_coef_addr_gen: coefficient address = layer base + node * fan_in + input index.
module ann_coef_addr_gen
    import ann_pkg::*;
#(
    parameter int ADDR_W = COEF_ADDR_W
) (
    input  logic              layer_i,
    input  logic [NODE_W-1:0] node_i,
    input  logic [IN_W-1:0]   in_i,
    output logic [ADDR_W-1:0] addr_o
);
    assign addr_o = ADDR_W'(base(layer_i) + int'(node_i) * fan_in(layer_i) + int'(in_i));
endmodule

// File: rtl/ann_layer_sequencer.sv
// ann_layer_sequencer: walks every node of both layers, fetching coefficients and pulsing MAC controls.
module ann_layer_sequencer
    import ann_pkg::*;
#(
    parameter int ADDR_W = COEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              weights_loaded,
    output logic              coef_req,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic              coef_ack,
    output logic              layer_sel,
    output logic [4:0]        in_sel,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              act_en,
    output logic [1:0]        store_idx,
    output logic              busy,
    output logic              done
);
    seq_state_t        state_q, state_d;
    logic              layer_q, layer_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic [IN_W-1:0]   in_q, in_d;
    logic [ADDR_W-1:0] addr_d;
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        node_d  = node_q;
        in_d    = in_q;
        case (state_q)
            IDLE:      if (start) state_d = weights_loaded ? CLEAR : WAIT_LOAD;
            WAIT_LOAD: if (weights_loaded) state_d = CLEAR;
            CLEAR: begin
                in_d    = '0;
                state_d = REQ;
            end
            REQ:       if (coef_ack) state_d = ACCUM;
            ACCUM: begin
                state_d = (in_q == IN_W'(fan_in(layer_q) - 1)) ? STORE : REQ;
                in_d    = (state_d == REQ) ? in_q + IN_W'(1) : in_q;
            end
            STORE: begin
                if (node_q != NODE_W'(nodes(layer_q) - 1)) begin
                    node_d  = node_q + NODE_W'(1);
                    state_d = CLEAR;
                end else if (!layer_q) begin
                    layer_d = 1'b1;
                    node_d  = '0;
                    state_d = CLEAR;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                layer_d = 1'b0;
                node_d  = '0;
                in_d    = '0;
            end
        endcase
    end
    ann_coef_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .layer_i(layer_d),
        .node_i (node_d),
        .in_i   (in_d),
        .addr_o (addr_d)
    );
    // Outputs are decoded from the next state so they are registered yet line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            layer_q   <= 1'b0;
            node_q    <= '0;
            in_q      <= '0;
            coef_req  <= 1'b0;
            coef_addr <= '0;
            layer_sel <= 1'b0;
            in_sel    <= '0;
            acc_clear <= 1'b0;
            acc_en    <= 1'b0;
            act_en    <= 1'b0;
            store_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            node_q    <= node_d;
            in_q      <= in_d;
            coef_req  <= state_d == REQ;
            coef_addr <= (state_d == REQ) ? addr_d : '0;
            layer_sel <= (state_d == ACCUM) && layer_d;
            in_sel    <= (state_d == ACCUM) ? 5'(in_d) : '0;
            acc_clear <= state_d == CLEAR;
            acc_en    <= state_d == ACCUM;
            act_en    <= state_d == STORE;
            store_idx <= (state_d == STORE) ? 2'(node_d) : '0;
            busy      <= state_d != IDLE;
            done      <= state_d == DONE;
        end
    end
endmodule

// File: tb/tb_ann_layer_sequencer.sv
// tb_ann_layer_sequencer: table of image runs with random ack stalls, checked against a sequential-count model.
module tb_ann_layer_sequencer;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, weights_loaded = 1'b0, coef_ack = 1'b0;
    logic       coef_req, layer_sel, acc_clear, acc_en, act_en, busy, done;
    logic [7:0] coef_addr;
    logic [4:0] in_sel;
    logic [1:0] store_idx;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    ann_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .weights_loaded(weights_loaded),
        .coef_req(coef_req), .coef_addr(coef_addr), .coef_ack(coef_ack),
        .layer_sel(layer_sel), .in_sel(in_sel), .acc_clear(acc_clear), .acc_en(acc_en),
        .act_en(act_en), .store_idx(store_idx), .busy(busy), .done(done)
    );
    function automatic int outs();
        return int'({coef_req, coef_addr, layer_sel, in_sel, acc_clear, acc_en, act_en, store_idx, busy, done});
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    typedef struct {
        bit wl0;
        int load_at;
        int max_stall;
        bit poke;
        int exp_acc;
        int exp_act;
        int exp_lat;
    } vec_t;
    // The network walks weights in address order, so the k-th fetch must be address k.
    task automatic run_image(input vec_t v);
        int cyc = 0, stalls = 0, nacc = 0, nack = 0, ndone = 0, done_cyc = -1, first_clr = -1;
        int stall_left, clr_cyc;
        bit ack_prev = 0, pend = 0, cur_ack;
        logic [7:0] paddr = 0;
        int sidx[$];
        int exp_idx[5] = '{0, 1, 2, 3, 0};
        stall_left = $urandom_range(v.max_stall);
        clr_cyc = v.wl0 ? 1 : v.load_at + 1;
        @(negedge clk);
        weights_loaded = v.wl0;
        start = 1'b1;
        coef_ack = 1'b0;
        while (cyc < 3000 && !(ndone > 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            chk("acc_en_after_ack", acc_en, ack_prev);
            if (pend) chk("req_held", coef_req, 1);
            if (acc_en) begin
                chk("in_sel", in_sel, nacc < 64 ? nacc % 16 : (nacc - 64) % 4);
                chk("layer_sel", layer_sel, nacc >= 64);
                nacc++;
            end
            if (act_en) sidx.push_back(store_idx);
            if (acc_clear && first_clr < 0) first_clr = cyc;
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (cyc < clr_cyc) begin
                chk("wait_load_req", coef_req, 0);
                chk("wait_load_busy", busy, 1);
            end
            cur_ack = 0;
            if (coef_req) begin
                if (pend) chk("stall_addr", coef_addr, paddr);
                pend = 1;
                paddr = coef_addr;
                if (stall_left > 0) begin
                    coef_ack = 1'b0;
                    stall_left--;
                    stalls++;
                end else begin
                    coef_ack = 1'b1;
                    cur_ack = 1;
                    chk("coef_addr", coef_addr, nack);
                    nack++;
                    pend = 0;
                    stall_left = $urandom_range(v.max_stall);
                end
            end else begin
                coef_ack = 1'($urandom_range(1));
            end
            ack_prev = cur_ack;
            start = v.poke && (done || (busy && $urandom_range(7) == 0));
            if (!v.wl0 && cyc == v.load_at) weights_loaded = 1'b1;
            else if (v.poke && cyc > clr_cyc) weights_loaded = 1'($urandom_range(1));
        end
        start = 1'b0;
        chk("done_count", ndone, 1);
        chk("done_latency", done_cyc, clr_cyc + v.exp_lat + stalls);
        chk("first_clear", first_clr, clr_cyc);
        chk("acc_count", nacc, v.exp_acc);
        chk("ack_count", nack, v.exp_acc);
        chk("act_count", sidx.size(), v.exp_act);
        for (int i = 0; i < sidx.size() && i < 5; i++) chk("store_idx", sidx[i], exp_idx[i]);
        chk("idle_busy", busy, 0);
    endtask
    initial begin
        vec_t tbl[5];
        tbl = '{
            '{1, 0, 0, 0, 68, 5, 146},
            '{1, 0, 5, 0, 68, 5, 146},
            '{0, 20, 0, 0, 68, 5, 146},
            '{1, 0, 5, 1, 68, 5, 146},
            '{0, 7, 3, 1, 68, 5, 146}
        };
        repeat (2) @(negedge clk);
        chk("reset_outs", outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        weights_loaded = 1'b1;
        start = 1'b1;
        coef_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("clear_after_start", acc_clear, 1);
        @(negedge clk);
        chk("req_before_rst", coef_req, 1);
        @(negedge clk);
        chk("req_stalled", coef_req, 1);
        #2 rst = 1'b1;
        #1 chk("async_rst_outs", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outs_held", outs(), 0);
        @(negedge clk);
        chk("no_restart", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_clear", acc_clear, 1);
        chk("restart_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) run_image(tbl[i]);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
